// File: rtl/mac_accumulate_unit_pkg.sv
// Shared types and helpers for mac_accumulate_unit: FSM state encoding,
// result narrowing/saturation and elaboration-time width checks.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    function automatic int min_acc_width(input int in_width, input int acc_length);
        return 2 * in_width + $clog2(acc_length);
    endfunction

    function automatic int cnt_width(input int acc_length);
        return (acc_length > 1) ? $clog2(acc_length) : 1;
    endfunction

    function automatic logic signed [63:0] out_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] out_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic logic out_of_range(input logic signed [63:0] r, input int width);
        return (r > out_max(width)) || (r < out_min(width));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] r, input int width);
        if (r > out_max(width)) return out_max(width);
        if (r < out_min(width)) return out_min(width);
        return r;
    endfunction

endpackage

// File: rtl/mac_accumulate_unit_if.sv
// Operand input stream and result output stream of mac_accumulate_unit.
// The slave modport is the unit itself; master is whoever drives operands and takes results.
interface mac_accumulate_unit_if #(
    parameter int DataInputWidth  = 8,
    parameter int DataOutputWidth = 8
);
    logic                               InValid;
    logic                               InReady;
    logic signed [DataInputWidth-1:0]   InA;
    logic signed [DataInputWidth-1:0]   InB;
    logic                               InLast;
    logic                               OutValid;
    logic                               OutReady;
    logic signed [DataOutputWidth-1:0]  DataOut;
    logic                               OutOvf;

    modport master (
        output InValid, InA, InB, InLast, OutReady,
        input  InReady, OutValid, DataOut, OutOvf
    );

    modport slave (
        input  InValid, InA, InB, InLast, OutReady,
        output InReady, OutValid, DataOut, OutOvf
    );
endinterface

// File: rtl/mac_mult_stage.sv
// Registered signed multiplier; carries frame-position flags alongside the product
// so the accumulator sees first/last markers aligned with the product.
module mac_mult_stage #(
    parameter int Width = 8
) (
    input  logic                      clk,
    input  logic                      sclr,
    input  logic                      valid,
    input  logic signed [Width-1:0]   a,
    input  logic signed [Width-1:0]   b,
    input  logic                      first,
    input  logic                      last,
    output logic signed [2*Width-1:0] product,
    output logic                      product_valid,
    output logic                      product_first,
    output logic                      product_last
);

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            product       <= '0;
            product_valid <= 1'b0;
            product_first <= 1'b0;
            product_last  <= 1'b0;
        end else begin
            product_valid <= valid;
            if (valid) begin
                product       <= (2*Width)'(a) * (2*Width)'(b);
                product_first <= first;
                product_last  <= last;
            end
        end
    end

endmodule

// File: rtl/mac_accumulate_unit.sv
// Signed multiply-accumulate over frames of AccLength beats (or shorter on InLast).
// Define MAC_SATURATE_EN to clamp out-of-range results instead of wrapping.
//
// state | meaning
// IDLE  | no frame open
// ACCUM | frame open, accepting beats
// FINAL | last product in flight, input stalled
// HOLD  | result held until taken downstream
module mac_accumulate_unit
    import mac_pkg::*;
#(
    parameter int DataInputWidth  = 8,
    parameter int DataOutputWidth = 8,
    parameter int AccWidth        = 24,
    parameter int AccLength       = 16,
    parameter int OutShift        = 0
) (
    input  logic             clk,
    input  logic             sclr,
    mac_accumulate_unit_if.slave bus
);

    localparam int CntWidth = cnt_width(AccLength);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(AccLength - 1);

    generate
        if (AccLength < 1 || AccWidth > 64 || DataOutputWidth > AccWidth ||
            AccWidth < min_acc_width(DataInputWidth, AccLength)) begin : g_bad_params
            $error("mac_accumulate_unit: AccWidth too small for operand width and AccLength");
        end
    endgenerate

    mac_state_t state, state_next;
    logic [CntWidth-1:0] count;
    logic in_ready, beat, last_beat, first_beat;

    logic signed [2*DataInputWidth-1:0] product;
    logic product_valid, product_first, product_last;

    logic signed [AccWidth-1:0] acc, acc_base, acc_sum, shifted;
    logic signed [63:0] wide_result, narrowed;
    logic ovf;

    assign bus.InReady = in_ready & ~sclr;
    assign beat        = bus.InValid & bus.InReady;
    assign first_beat  = (count == '0);
    assign last_beat   = bus.InLast | (count == LastCount);

    mac_mult_stage #(.Width(DataInputWidth)) u_mult (
        .clk           (clk),
        .sclr          (sclr),
        .valid         (beat),
        .a             (bus.InA),
        .b             (bus.InB),
        .first         (first_beat),
        .last          (last_beat),
        .product       (product),
        .product_valid (product_valid),
        .product_first (product_first),
        .product_last  (product_last)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready = 1'b1;
            HOLD:        in_ready = bus.OutReady;
            default:     in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat) state_next = last_beat ? FINAL : ACCUM;
            end
            FINAL: state_next = HOLD;
            HOLD: begin
                // Retiring the result and opening a new frame can share one cycle.
                if (bus.OutReady) begin
                    if (beat) state_next = last_beat ? FINAL : ACCUM;
                    else      state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign acc_base    = product_first ? '0 : acc;
    assign acc_sum     = acc_base + AccWidth'(product);
    assign shifted     = acc_sum >>> OutShift;
    assign wide_result = 64'(shifted);
    assign ovf         = out_of_range(wide_result, DataOutputWidth);

`ifdef MAC_SATURATE_EN
    assign narrowed = saturate(wide_result, DataOutputWidth);
`else
    assign narrowed = wide_result;
`endif

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            bus.OutValid <= 1'b0;
            bus.DataOut  <= '0;
            bus.OutOvf   <= 1'b0;
        end else begin
            state <= state_next;
            if (beat) count <= last_beat ? '0 : count + CntWidth'(1);
            if (product_valid) acc <= acc_sum;
            if (product_valid && product_last) begin
                bus.OutValid <= 1'b1;
                bus.DataOut  <= DataOutputWidth'(narrowed);
                bus.OutOvf   <= ovf;
            end else if (bus.OutValid && bus.OutReady) begin
                bus.OutValid <= 1'b0;
            end
        end
    end

endmodule
